// File: rtl/audio_pkg.sv
// Shared encodings for the codec frame sequencer: source modes, FSM states
// and the default sample width.
package audio_pkg;

   localparam int DATA_W_DEF = 24;

   typedef enum logic [1:0] {
      MODE_MUTE = 2'd0,
      MODE_PASS = 2'd1,
      MODE_TONE = 2'd2,
      MODE_MIX  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FETCH    = 2'd1,
      ST_WAIT_ROM = 2'd2,
      ST_WRITE    = 2'd3
   } state_e;

endpackage

// File: rtl/audio_path_ctrl_if.sv
// Codec FIFO + tone ROM signal bundle. master = frame sequencer,
// slave = codec/ROM side.
interface audio_path_ctrl_if #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 16
);
   logic              read_ready;
   logic              write_ready;
   logic [DATA_W-1:0] readdata_left;
   logic [DATA_W-1:0] readdata_right;
   logic [DATA_W-1:0] rom_q;
   logic [ADDR_W-1:0] rom_addr;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata_left;
   logic [DATA_W-1:0] writedata_right;
   logic              busy;

   modport master (
      input  read_ready, write_ready, readdata_left, readdata_right, rom_q,
      output rom_addr, read, write, writedata_left, writedata_right, busy
   );

   modport slave (
      output read_ready, write_ready, readdata_left, readdata_right, rom_q,
      input  rom_addr, read, write, writedata_left, writedata_right, busy
   );
endinterface

// File: rtl/tone_addr_gen.sv
// Tone ROM address counter: advances by one when en is high and wraps from
// ROM_DEPTH-1 back to 0.
module tone_addr_gen #(
   parameter int ROM_DEPTH = 48000,
   parameter int ADDR_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic [ADDR_W-1:0] rom_addr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);

   logic [ADDR_W-1:0] addr_q, addr_d;

   always_comb begin
      addr_d = addr_q;
      if (en) begin
         addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   assign rom_addr = addr_q;

endmodule

// File: rtl/audio_path_ctrl.sv
// Registered frame sequencer: pops one stereo mic frame and/or waits for the
// tone ROM, then pushes one selected/mixed frame into the DAC FIFO.
module audio_path_ctrl
   import audio_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ROM_DEPTH = 48000,
   parameter int ADDR_W    = 16,
   parameter int ROM_LAT   = 2
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [1:0]  mode,
   audio_path_ctrl_if.master bus
);

   localparam logic [1:0] WAIT_INIT = 2'((ROM_LAT > 0) ? ROM_LAT - 1 : 0);

   state_e            state_q, state_d;
   mode_e             mode_q, mode_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] mic_l_q, mic_l_d, mic_r_q, mic_r_d;
   logic [DATA_W-1:0] wd_l_q, wd_l_d, wd_r_q, wd_r_d;

   logic              start;
   logic              addr_en;
   logic [DATA_W-1:0] fetch_l, fetch_r;
   logic [DATA_W-1:0] src_l, src_r;
   mode_e             mode_in;

   function automatic logic [DATA_W-1:0] select_sample(
      input mode_e             m,
      input logic [DATA_W-1:0] mic,
      input logic [DATA_W-1:0] rom
   );
      logic signed [DATA_W-1:0] mic_s, rom_s;
      mic_s = mic;
      rom_s = rom;
      case (m)
         MODE_MUTE: select_sample = '0;
         MODE_PASS: select_sample = mic;
         MODE_TONE: select_sample = rom;
         // Halving both operands first keeps the sum inside DATA_W.
         default:   select_sample = DATA_W'((mic_s >>> 1) + (rom_s >>> 1));
      endcase
   endfunction

   assign mode_in = mode_e'(mode);
   assign start   = bus.write_ready &&
                    (bus.read_ready || mode_in == MODE_MUTE || mode_in == MODE_TONE);
   assign fetch_l = bus.read_ready ? bus.readdata_left  : '0;
   assign fetch_r = bus.read_ready ? bus.readdata_right : '0;
   // With ROM_LAT=0 the output load happens on the FETCH edge itself.
   assign src_l   = (state_q == ST_FETCH) ? fetch_l : mic_l_q;
   assign src_r   = (state_q == ST_FETCH) ? fetch_r : mic_r_q;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      mic_l_d = mic_l_q;
      mic_r_d = mic_r_q;
      wd_l_d  = wd_l_q;
      wd_r_d  = wd_r_q;
      case (state_q)
         ST_IDLE: begin
            mode_d = mode_in;
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            mic_l_d = fetch_l;
            mic_r_d = fetch_r;
            cnt_d   = WAIT_INIT;
            if (ROM_LAT == 0) begin
               state_d = ST_WRITE;
               wd_l_d  = select_sample(mode_q, src_l, bus.rom_q);
               wd_r_d  = select_sample(mode_q, src_r, bus.rom_q);
            end else begin
               state_d = ST_WAIT_ROM;
            end
         end
         ST_WAIT_ROM: begin
            if (cnt_q == 2'd0) begin
               state_d = ST_WRITE;
               wd_l_d  = select_sample(mode_q, src_l, bus.rom_q);
               wd_r_d  = select_sample(mode_q, src_r, bus.rom_q);
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_MUTE;
         cnt_q   <= '0;
         mic_l_q <= '0;
         mic_r_q <= '0;
         wd_l_q  <= '0;
         wd_r_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         mic_l_q <= mic_l_d;
         mic_r_q <= mic_r_d;
         wd_l_q  <= wd_l_d;
         wd_r_q  <= wd_r_d;
      end
   end

   assign addr_en = (state_q == ST_WRITE) && (mode_q == MODE_TONE || mode_q == MODE_MIX);

   tone_addr_gen #(
      .ROM_DEPTH (ROM_DEPTH),
      .ADDR_W    (ADDR_W)
   ) u_addr (
      .clk      (CLOCK_50),
      .rst      (reset),
      .en       (addr_en),
      .rom_addr (bus.rom_addr)
   );

   assign bus.read            = (state_q == ST_FETCH) && bus.read_ready;
   assign bus.write           = (state_q == ST_WRITE);
   assign bus.busy            = (state_q != ST_IDLE);
   assign bus.writedata_left  = wd_l_q;
   assign bus.writedata_right = wd_r_q;

endmodule

// File: tb/tb_audio_path_ctrl.sv
// Scoreboard bench for audio_path_ctrl: directed frames then random traffic,
// checked against a frame-level model of the sequencer.
module tb_audio_path_ctrl;

   localparam int DW    = 24;
   localparam int AW    = 16;
   localparam int DEPTH = 4;
   localparam int LAT   = 2;

   typedef struct {
      int          cyc;
      logic [DW-1:0] l;
      logic [DW-1:0] r;
      logic [AW-1:0] addr;
   } wexp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] mode = 2'd0;

   audio_path_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   audio_path_ctrl #(
      .DATA_W    (DW),
      .ROM_DEPTH (DEPTH),
      .ADDR_W    (AW),
      .ROM_LAT   (LAT)
   ) dut (
      .CLOCK_50 (clk),
      .reset    (rst),
      .mode     (mode),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Tone ROM with LAT registered stages.
   logic [DW-1:0] rom_mem [DEPTH];
   logic [DW-1:0] rom_p1, rom_p2;
   always @(posedge clk) begin
      rom_p1 <= rom_mem[bus.rom_addr[1:0]];
      rom_p2 <= rom_p1;
   end
   assign bus.rom_q = rom_p2;

   int    n_checks = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   bit    active   = 0;
   int    start_c  = 0;
   logic [1:0] fmode = 2'd0;
   int    addr_m   = 0;
   bit    exp_busy = 0;
   logic [DW-1:0] last_l = '0, last_r = '0;
   int    rq[$];
   wexp_t wq[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int floor_half(input int x);
      return (x - (x & 1)) / 2;
   endfunction

   function automatic logic [DW-1:0] expect_sample(input logic [1:0] m,
                                                   input logic [DW-1:0] mic,
                                                   input logic [DW-1:0] tone);
      int a, b;
      a = int'($signed(mic));
      b = int'($signed(tone));
      case (m)
         2'd0:    return '0;
         2'd1:    return mic;
         2'd2:    return tone;
         default: return DW'(floor_half(a) + floor_half(b));
      endcase
   endfunction

   // Frame-level reference: a frame starting at cycle s pops at s+1, writes at
   // s+2+LAT and leaves the controller free again at s+3+LAT.
   task automatic model_step();
      wexp_t w;
      logic [DW-1:0] ml, mr;
      int ph;
      if (active) begin
         exp_busy = 1;
         ph = cyc - start_c;
         if (ph == 1) begin
            ml = bus.read_ready ? bus.readdata_left  : '0;
            mr = bus.read_ready ? bus.readdata_right : '0;
            if (bus.read_ready) rq.push_back(cyc);
            w.cyc  = start_c + 2 + LAT;
            w.l    = expect_sample(fmode, ml, rom_mem[addr_m]);
            w.r    = expect_sample(fmode, mr, rom_mem[addr_m]);
            w.addr = AW'(addr_m);
            wq.push_back(w);
            if (fmode >= 2'd2) addr_m = (addr_m + 1) % DEPTH;
         end
         if (ph == 2 + LAT) active = 0;
      end else begin
         exp_busy = 0;
         if (bus.write_ready && (bus.read_ready || mode == 2'd0 || mode == 2'd2)) begin
            active  = 1;
            start_c = cyc;
            fmode   = mode;
         end
      end
   endtask

   task automatic drive(input logic [1:0] m, input logic rr, input logic wr,
                        input logic [DW-1:0] l, input logic [DW-1:0] r);
      @(posedge clk);
      #1;
      cyc++;
      mode               = m;
      bus.read_ready     = rr;
      bus.write_ready    = wr;
      bus.readdata_left  = l;
      bus.readdata_right = r;
      model_step();
   endtask

   // Async reset asserted mid-cycle; outputs must clear without waiting for a clock.
   task automatic apply_reset();
      #2 rst = 1'b1;
      #1;
      check("rst_read",  {63'd0, bus.read},  64'd0);
      check("rst_write", {63'd0, bus.write}, 64'd0);
      check("rst_busy",  {63'd0, bus.busy},  64'd0);
      check("rst_wd_l",  {40'd0, bus.writedata_left},  64'd0);
      check("rst_wd_r",  {40'd0, bus.writedata_right}, 64'd0);
      check("rst_addr",  {48'd0, bus.rom_addr}, 64'd0);
      active = 0;
      addr_m = 0;
      rq.delete();
      wq.delete();
      last_l = '0;
      last_r = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc++;
      bus.write_ready = 1'b0;
      bus.read_ready  = 1'b0;
      exp_busy = 0;
   endtask

   // Monitor: pops expectations whenever the DUT strobes.
   initial begin
      wexp_t w;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("busy", {63'd0, bus.busy}, {63'd0, exp_busy});
            if (bus.read && bus.write) check("read_write_overlap", 64'd1, 64'd0);
            while (rq.size() > 0 && rq[0] < cyc) begin
               check("read_missed_at", 64'(cyc), 64'(rq[0]));
               void'(rq.pop_front());
            end
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
               check("write_missed_at", 64'(cyc), 64'(wq[0].cyc));
               void'(wq.pop_front());
            end
            if (bus.read) begin
               if (rq.size() == 0) check("read_unexpected", 64'(cyc), 64'hFFFF_FFFF);
               else check("read_cycle", 64'(cyc), 64'(rq.pop_front()));
            end
            if (bus.write) begin
               if (wq.size() == 0) begin
                  check("write_unexpected", 64'(cyc), 64'hFFFF_FFFF);
               end else begin
                  w = wq.pop_front();
                  check("write_cycle", 64'(cyc), 64'(w.cyc));
                  check("write_addr", {48'd0, bus.rom_addr}, {48'd0, w.addr});
                  last_l = w.l;
                  last_r = w.r;
                  $display("write cyc=%0d L=%06h R=%06h addr=%0d", cyc,
                           bus.writedata_left, bus.writedata_right, bus.rom_addr);
               end
            end
            check("wd_left",  {40'd0, bus.writedata_left},  {40'd0, last_l});
            check("wd_right", {40'd0, bus.writedata_right}, {40'd0, last_r});
         end
      end
   end

   initial begin
      int guard;
      logic [1:0] rm;
      rom_mem[0] = 24'h7FFFFF;
      rom_mem[1] = 24'hFFFFFE;
      rom_mem[2] = 24'($urandom);
      rom_mem[3] = 24'($urandom);
      bus.read_ready = 0; bus.write_ready = 0;
      bus.readdata_left = '0; bus.readdata_right = '0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;

      // Mix arithmetic: ROM[0]=7FFFFF, ROM[1]=FFFFFE.
      drive(2'd3, 1, 1, 24'h7FFFFF, 24'h7FFFFF);
      repeat (4) drive(2'd3, 1, 0, 24'h7FFFFF, 24'h7FFFFF);
      drive(2'd3, 1, 1, 24'h800000, 24'h800000);
      repeat (4) drive(2'd3, 1, 0, 24'h800000, 24'h800000);

      // Reset during WAIT_ROM with a non-zero ROM address.
      guard = 0;
      do begin
         drive(2'd1, 1, 1, 24'h0A0B0C, 24'h0D0E0F);
         guard++;
      end while (!(active && cyc - start_c == 2) && guard < 20);
      check("reach_wait_rom", 64'(guard < 20), 64'd1);
      apply_reset();

      // Passthrough frame.
      drive(2'd1, 1, 1, 24'h123456, 24'hFEDCBA);
      repeat (5) drive(2'd1, 1, 0, 24'h123456, 24'hFEDCBA);

      // Gating: passthrough without mic data never starts; mute does.
      repeat (6) drive(2'd1, 0, 1, 24'h111111, 24'h222222);
      repeat (6) drive(2'd0, 0, 1, 24'h111111, 24'h222222);
      repeat (3) drive(2'd0, 0, 0, '0, '0);

      // Tone playback through the address wrap.
      repeat (25) drive(2'd2, 0, 1, 24'h333333, 24'h444444);

      // Mode switched tone->passthrough during WAIT_ROM.
      drive(2'd2, 1, 1, 24'h555555, 24'h666666);
      drive(2'd2, 1, 0, 24'h555555, 24'h666666);
      repeat (10) drive(2'd1, 1, 1, 24'h777777, 24'h888888);

      // Random traffic with occasional mode changes.
      rm = 2'd1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) rm = 2'($urandom_range(0, 3));
         drive(rm, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 8),
               24'($urandom), 24'($urandom));
         if (i == 1500 && active) apply_reset();
      end

      repeat (10) drive(2'd0, 0, 0, '0, '0);
      @(negedge clk);
      #1;
      check("reads_drained",  64'(rq.size()), 64'd0);
      check("writes_drained", 64'(wq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/audio_path_ctrl.md
Name: audio_path_ctrl

Overview:
- Frame sequencer for the codec datapath: one stereo frame per handshake, consumed from codec ADC FIFO and/or tone ROM, driven to codec DAC FIFO.
- Replaces direct combinational read/write gating with a registered FSM; owns tone ROM address.
- Selectable source: mute, mic passthrough, tone playback, mic+tone mix.
- Sits between codec interface and tone ROM, under top-level mode switches.

Parameters:
- DATA_W, 24, audio sample width (two's complement).
- ROM_DEPTH, 48000, number of tone samples in ROM.
- ADDR_W, 16, ROM address width; must satisfy 2^ADDR_W >= ROM_DEPTH.
- ROM_LAT, 2, ROM read latency in cycles (address stable to q valid), range 0..3.

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mode  in  2  0=mute, 1=passthrough, 2=tone, 3=mix
- read_ready  in  1  codec ADC FIFO holds a sample
- write_ready  in  1  codec DAC FIFO has space
- readdata_left  in  DATA_W  mic left sample
- readdata_right  in  DATA_W  mic right sample
- rom_q  in  DATA_W  tone ROM output (mono)
- rom_addr  out  ADDR_W  tone ROM address (registered)
- read  out  1  one-cycle pop strobe to ADC FIFO
- write  out  1  one-cycle push strobe to DAC FIFO
- writedata_left  out  DATA_W  registered left output sample
- writedata_right  out  DATA_W  registered right output sample
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state): state=IDLE, rom_addr=0, read=0, write=0, writedata_*=0, busy=0.
- States: IDLE, FETCH, WAIT_ROM, WRITE.
- IDLE: latch mode into mode_q. Start when write_ready=1 AND (read_ready=1 OR mode in {0,2}); go to FETCH. Otherwise stay.
- FETCH (1 cycle): read=1 iff read_ready=1 this cycle; mic samples latched into mic_l/mic_r on same edge; if no pop, mic_l/mic_r=0. Next: WAIT_ROM if ROM_LAT>0, else WRITE.
- WAIT_ROM: exactly ROM_LAT cycles via down-counter, then WRITE.
- Output select, loaded into writedata_* on the edge entering WRITE:
  - mute: 0 both channels.
  - passthrough: mic_l/mic_r.
  - tone: rom_q both channels.
  - mix: (mic>>>1)+(rom_q>>>1) per channel, arithmetic shift, DATA_W result, no overflow possible.
- WRITE (1 cycle): write=1; writedata_* stable and held until the next WRITE load. Next: IDLE.
- Latency: start condition at cycle t -> read at t+1 -> write at t+2+ROM_LAT -> IDLE at t+3+ROM_LAT. Max throughput: one frame per 3+ROM_LAT cycles.
- rom_addr: increments at end of WRITE only when mode_q in {2,3}. ROM_DEPTH-1 wraps to 0. Held in modes 0/1; not cleared on mode change.
- mode changes mid-frame are ignored; they take effect at the next IDLE.
- write_ready/read_ready are sampled only in IDLE and FETCH. The controller is sole DAC writer, so space persists once granted.
- read and write are never asserted in the same cycle.
- reset mid-frame aborts the frame: no write issued, no address increment.

Decomposition:
- Package audio_pkg:
  - mode encodings MODE_MUTE/PASS/TONE/MIX.
  - state enum.
  - DATA_W default.
- Sub-module tone_addr_gen: wrapping counter with en, reset, ROM_DEPTH/ADDR_W parameters; output rom_addr.
- FSM, mixer and output registers stay in audio_path_ctrl.

Test Plan:
- Reset mid-WAIT_ROM: assert reset -> all outputs 0 same cycle; rom_addr=0; no write pulse; state IDLE after release.
- Passthrough, ROM_LAT=2:
  - Stimulus: mode=1, read_ready=write_ready=1 at t, readdata_left=24'h123456, readdata_right=24'hFEDCBA.
  - Response: read=1 only at t+1; write=1 only at t+4 with those values; rom_addr unchanged.
- Tone wrap, ROM_DEPTH=4, mode=2, write_ready=1, read_ready=0:
  - Response: no read pulses; write every 5 cycles; rom_addr sequence 0,1,2,3,0.
  - writedata_left=writedata_right=rom_q each frame.
- Mix arithmetic, mode=3:
  - Stimulus 1: mic=24'h7FFFFF, rom_q=24'h7FFFFF -> output 24'h7FFFFE.
  - Stimulus 2: mic=24'h800000, rom_q=24'hFFFFFE -> output 24'hBFFFFF.
- Gating, mode=1:
  - write_ready=1, read_ready=0 -> stays IDLE, no strobes.
  - Same gating in mode=0 -> frame runs, read=0, writes 0.
- Mode change mid-frame: switch 2->1 during WAIT_ROM -> current frame outputs rom_q and increments rom_addr; next frame is passthrough with rom_addr held.
